// File: rtl/image_blur_pkg.sv
// Shared constants for the image_blur frame filter: kernel codes, FSM state
// encoding and the accumulator width used by the kernel datapath.
package image_blur_pkg;

  localparam logic [1:0] KERNEL_ID    = 2'd0;
  localparam logic [1:0] KERNEL_BOX   = 2'd1;
  localparam logic [1:0] KERNEL_GAUSS = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam int SUM_W = 12;

endpackage

// File: rtl/image_blur_kernel.sv
// Combinational 3x3 kernel: taps are row-major (index 4 is the centre).
// Rounding to nearest is selected with IMAGE_BLUR_ROUND_EN; default truncates.
module image_blur_kernel
  import image_blur_pkg::*;
(
  input  logic [8:0][7:0] i_taps,
  input  logic [1:0]      i_kernel,
  output logic [7:0]      o_pix
);

`ifdef IMAGE_BLUR_ROUND_EN
  localparam logic [SUM_W-1:0] BOX_BIAS   = SUM_W'(4);
  localparam logic [SUM_W-1:0] GAUSS_BIAS = SUM_W'(8);
`else
  localparam logic [SUM_W-1:0] BOX_BIAS   = '0;
  localparam logic [SUM_W-1:0] GAUSS_BIAS = '0;
`endif

  logic [SUM_W-1:0] w_box_sum;
  logic [SUM_W-1:0] w_gauss_sum;

  function automatic logic [SUM_W-1:0] ext(input logic [7:0] t);
    return SUM_W'(t);
  endfunction

  assign w_box_sum = ext(i_taps[0]) + ext(i_taps[1]) + ext(i_taps[2])
                   + ext(i_taps[3]) + ext(i_taps[4]) + ext(i_taps[5])
                   + ext(i_taps[6]) + ext(i_taps[7]) + ext(i_taps[8]);

  // Weights 1 2 1 / 2 4 2 / 1 2 1 as shifts.
  assign w_gauss_sum = ext(i_taps[0]) + (ext(i_taps[1]) << 1) + ext(i_taps[2])
                     + (ext(i_taps[3]) << 1) + (ext(i_taps[4]) << 2) + (ext(i_taps[5]) << 1)
                     + ext(i_taps[6]) + (ext(i_taps[7]) << 1) + ext(i_taps[8]);

  always_comb begin
    o_pix = i_taps[4];
    case (i_kernel)
      KERNEL_BOX:   o_pix = 8'((w_box_sum + BOX_BIAS) / SUM_W'(9));
      KERNEL_GAUSS: o_pix = 8'((w_gauss_sum + GAUSS_BIAS) >> 4);
      default:      o_pix = i_taps[4];
    endcase
  end

endmodule

// File: rtl/image_blur.sv
// Frame-buffered 3x3 RGB blur: load a whole frame, then stream it filtered.
// Optional rounding in the kernel is enabled by defining IMAGE_BLUR_ROUND_EN.
module image_blur
  import image_blur_pkg::*;
#(
  parameter int WIDTH  = 788,
  parameter int HEIGHT = 1080
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] kernel_type,
  input  logic [7:0] image_in,
  output logic [7:0] image_out,
  output logic       done,
  output logic [1:0] o_dbg_state
);

  localparam int N  = WIDTH * HEIGHT * 3;
  localparam int AW = $clog2(N + 1);
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);

  logic [1:0]      r_state;
  logic [AW-1:0]   r_cnt;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [1:0]      r_c;
  logic [1:0]      r_kernel;
  logic [7:0]      r_out;
  logic            r_done;
  logic [7:0]      r_ram [N];
  logic [8:0][7:0] w_taps;
  logic [7:0]      w_pix;

  // Neighbour address with edge-replicate clamping; dx/dy of 1 is the centre.
  function automatic logic [AW-1:0] tap_addr(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                             input logic [1:0] c, input int dx, input int dy);
    logic [XW-1:0] xx;
    logic [YW-1:0] yy;
    xx = x;
    yy = y;
    if (dx == 0 && x != '0) xx = x - 1'b1;
    if (dx == 2 && x != XW'(WIDTH - 1)) xx = x + 1'b1;
    if (dy == 0 && y != '0) yy = y - 1'b1;
    if (dy == 2 && y != YW'(HEIGHT - 1)) yy = y + 1'b1;
    return (AW'(yy) * AW'(WIDTH) + AW'(xx)) * AW'(3) + AW'(c);
  endfunction

  for (genvar gy = 0; gy < 3; gy++) begin : g_row
    for (genvar gx = 0; gx < 3; gx++) begin : g_col
      assign w_taps[gy*3+gx] = r_ram[tap_addr(r_x, r_y, r_c, gx, gy)];
    end
  end

  image_blur_kernel u_kernel (
    .i_taps   (w_taps),
    .i_kernel (r_kernel),
    .o_pix    (w_pix)
  );

  // Frame RAM has no reset; contents are only meaningful after a full load.
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD) r_ram[r_cnt] <= image_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_c      <= '0;
      r_kernel <= KERNEL_ID;
      r_out    <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
          end
        end
        ST_LOAD: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == AW'(N - 1)) begin
            r_state  <= ST_STREAM;
            r_done   <= 1'b1;
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_c      <= '0;
            r_kernel <= kernel_type;
          end
        end
        ST_STREAM: begin
          if (r_cnt == AW'(N)) begin
            r_out   <= '0;
            r_state <= ST_HOLD;
          end else begin
            r_out <= w_pix;
            r_cnt <= r_cnt + 1'b1;
            // Walk channel, then column, then row, matching the byte layout.
            if (r_c == 2'd2) begin
              r_c <= '0;
              if (r_x == XW'(WIDTH - 1)) begin
                r_x <= '0;
                r_y <= (r_y == YW'(HEIGHT - 1)) ? '0 : r_y + 1'b1;
              end else begin
                r_x <= r_x + 1'b1;
              end
            end else begin
              r_c <= r_c + 1'b1;
            end
          end
        end
        default: begin
          if (!start) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign image_out   = r_out;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_image_blur.sv
// Self-checking bench for image_blur on a 5x5 frame plus a 2x2 instance for
// the corner-clamp case; expected bytes come from a coordinate-level model.
module tb_image_blur;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int N  = W * H * 3;
  localparam int W2 = 2;
  localparam int H2 = 2;
  localparam int N2 = W2 * H2 * 3;

  logic       clk;
  logic       reset;
  logic       a_start, b_start;
  logic [1:0] a_kern, b_kern;
  logic [7:0] a_in, b_in;
  logic [7:0] a_out, b_out;
  logic       a_done, b_done;
  logic [1:0] a_state, b_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] stim_a [$];
  logic [7:0] stim_b [$];
  logic [7:0] got_a  [N];
  logic [7:0] got_b  [N2];
  logic [7:0] exp_q  [$];

  logic       obs_done_es, obs_done_prelast, obs_done_load, obs_done_hold;
  logic       obs_done_hold2, obs_done_idle;
  logic [7:0] obs_out_e0, obs_out_hold, obs_out_idle;

  image_blur #(.WIDTH(W), .HEIGHT(H)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .kernel_type(a_kern),
    .image_in(a_in), .image_out(a_out), .done(a_done), .o_dbg_state(a_state)
  );

  image_blur #(.WIDTH(W2), .HEIGHT(H2)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .kernel_type(b_kern),
    .image_in(b_in), .image_out(b_out), .done(b_done), .o_dbg_state(b_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: direct 3x3 neighbourhood arithmetic on clamped coordinates.
  function automatic logic [7:0] model_pix(input logic [7:0] img [$], input int w, input int h,
                                           input int idx, input logic [1:0] kern);
    int c, p, x, y, xx, yy, sum, wt;
    c = idx % 3;
    p = idx / 3;
    x = p % w;
    y = p / w;
    if (kern != 2'd1 && kern != 2'd2) return img[idx];
    sum = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xx = x + dx;
        yy = y + dy;
        if (xx < 0) xx = 0;
        if (xx > w - 1) xx = w - 1;
        if (yy < 0) yy = 0;
        if (yy > h - 1) yy = h - 1;
        wt = (kern == 2'd1) ? 1 : ((dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1));
        sum += wt * int'(img[(yy * w + xx) * 3 + c]);
      end
    end
`ifdef IMAGE_BLUR_ROUND_EN
    if (kern == 2'd1) return 8'((sum + 4) / 9);
    return 8'((sum + 8) / 16);
`else
    if (kern == 2'd1) return 8'(sum / 9);
    return 8'(sum / 16);
`endif
  endfunction

  task automatic fill_a_random();
    stim_a.delete();
    for (int k = 0; k < N; k++) stim_a.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic build_exp_a(input logic [1:0] kern);
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(model_pix(stim_a, W, H, k, kern));
  endtask

  // Driver: full frame on dut_a; inputs change and outputs are sampled on negedges.
  task automatic run_frame_a(input logic [1:0] kern, input bit scramble);
    @(negedge clk);
    a_start = 1'b1;
    a_kern  = kern;
    @(negedge clk);
    obs_done_es = a_done;
    a_start = 1'b0;
    for (int k = 0; k < N; k++) begin
      a_in = stim_a[k];
      if (scramble) begin
        a_start = 1'($urandom_range(0, 1));
        a_kern  = (k == N - 1) ? kern : 2'($urandom_range(0, 3));
      end
      if (k == N - 1) obs_done_prelast = a_done;
      @(negedge clk);
    end
    obs_done_load = a_done;
    obs_out_e0    = a_out;
    a_start = scramble;
    for (int k = 0; k < N; k++) begin
      a_in = 8'($urandom_range(0, 255));
      if (scramble) a_kern = 2'($urandom_range(0, 3));
      @(negedge clk);
      got_a[k] = a_out;
    end
    @(negedge clk);
    obs_out_hold  = a_out;
    obs_done_hold = a_done;
    @(negedge clk);
    obs_done_hold2 = a_done;
    a_start = 1'b0;
    @(negedge clk);
    obs_done_idle = a_done;
    obs_out_idle  = a_out;
    a_kern = kern;
  endtask

  task automatic test_reset();
    a_start = 1'b0; a_kern = 2'd0; a_in = 8'd0;
    b_start = 1'b0; b_kern = 2'd0; b_in = 8'd0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", a_done); end
    n_tests++;
    if (a_out !== 8'h00) begin n_fail++; $display("FAIL reset_out got=%h exp=00", a_out); end
    n_tests++;
    if (a_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", a_state); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_constant();
    stim_a.delete();
    for (int k = 0; k < N; k++) stim_a.push_back(8'h80);
    for (int kk = 1; kk <= 2; kk++) begin
      run_frame_a(2'(kk), 1'b0);
      for (int k = 0; k < N; k++) begin
        n_tests++;
        if (got_a[k] !== 8'h80) begin
          n_fail++; $display("FAIL const_k%0d byte %0d got=%h exp=80", kk, k, got_a[k]);
        end
      end
    end
  endtask

  task automatic test_identity_ramp();
    stim_a.delete();
    for (int k = 0; k < N; k++) stim_a.push_back(8'(k % 256));
    run_frame_a(2'd0, 1'b0);
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (got_a[k] !== 8'(k % 256)) begin
        n_fail++; $display("FAIL ramp byte %0d got=%h exp=%h", k, got_a[k], 8'(k % 256));
      end
    end
  endtask

  task automatic test_impulse();
    logic [7:0] e, ctr, edg, cor;
    int x, y, c;
`ifdef IMAGE_BLUR_ROUND_EN
    ctr = 8'h40; edg = 8'h20; cor = 8'h10;
`else
    ctr = 8'h3F; edg = 8'h1F; cor = 8'h0F;
`endif
    stim_a.delete();
    for (int k = 0; k < N; k++) stim_a.push_back(8'h00);
    stim_a[(2 * W + 2) * 3] = 8'hFF;
    for (int kk = 1; kk <= 2; kk++) begin
      run_frame_a(2'(kk), 1'b0);
      for (int k = 0; k < N; k++) begin
        c = k % 3; x = (k / 3) % W; y = (k / 3) / W;
        e = 8'h00;
        if (c == 0 && x >= 1 && x <= 3 && y >= 1 && y <= 3) begin
          if (kk == 1) e = 8'h1C;
          else if (x == 2 && y == 2) e = ctr;
          else if (x == 2 || y == 2) e = edg;
          else e = cor;
        end
        n_tests++;
        if (got_a[k] !== e) begin
          n_fail++; $display("FAIL impulse_k%0d (%0d,%0d,%0d) got=%h exp=%h", kk, x, y, c, got_a[k], e);
        end
      end
    end
  endtask

  task automatic test_random_kernels();
    logic [1:0] kern;
    for (int i = 0; i < 6; i++) begin
      kern = (i < 4) ? 2'(i) : 2'($urandom_range(0, 3));
      fill_a_random();
      build_exp_a(kern);
      run_frame_a(kern, 1'b0);
      for (int k = 0; k < N; k++) begin
        n_tests++;
        if (got_a[k] !== exp_q[k]) begin
          n_fail++; $display("FAIL random_k%0d byte %0d got=%h exp=%h", kern, k, got_a[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_timing();
    fill_a_random();
    run_frame_a(2'd0, 1'b0);
    n_tests++;
    if (obs_done_es !== 1'b0) begin n_fail++; $display("FAIL timing_done_es got=%b exp=0", obs_done_es); end
    n_tests++;
    if (obs_done_prelast !== 1'b0) begin n_fail++; $display("FAIL timing_done_early got=%b exp=0", obs_done_prelast); end
    n_tests++;
    if (obs_done_load !== 1'b1) begin n_fail++; $display("FAIL timing_done_rise got=%b exp=1", obs_done_load); end
    n_tests++;
    if (obs_out_e0 !== 8'h00) begin n_fail++; $display("FAIL timing_out_e0 got=%h exp=00", obs_out_e0); end
    n_tests++;
    if (got_a[0] !== stim_a[0]) begin n_fail++; $display("FAIL timing_byte0 got=%h exp=%h", got_a[0], stim_a[0]); end
    n_tests++;
    if (got_a[N-1] !== stim_a[N-1]) begin n_fail++; $display("FAIL timing_last got=%h exp=%h", got_a[N-1], stim_a[N-1]); end
    n_tests++;
    if (obs_out_hold !== 8'h00) begin n_fail++; $display("FAIL hold_out got=%h exp=00", obs_out_hold); end
    n_tests++;
    if (obs_done_hold !== 1'b1) begin n_fail++; $display("FAIL hold_done got=%b exp=1", obs_done_hold); end
    n_tests++;
    if (obs_done_idle !== 1'b0) begin n_fail++; $display("FAIL idle_done got=%b exp=0", obs_done_idle); end
    n_tests++;
    if (obs_out_idle !== 8'h00) begin n_fail++; $display("FAIL idle_out got=%h exp=00", obs_out_idle); end
  endtask

  task automatic test_kernel_hold();
    fill_a_random();
    build_exp_a(2'd2);
    run_frame_a(2'd2, 1'b1);
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (got_a[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL kern_hold byte %0d got=%h exp=%h", k, got_a[k], exp_q[k]);
      end
    end
    n_tests++;
    if (obs_done_hold2 !== 1'b1) begin n_fail++; $display("FAIL hold_with_start got=%b exp=1", obs_done_hold2); end
    n_tests++;
    if (obs_done_idle !== 1'b0) begin n_fail++; $display("FAIL hold_release got=%b exp=0", obs_done_idle); end
  endtask

  task automatic test_reset_abort();
    fill_a_random();
    // Abort mid-load.
    @(negedge clk);
    a_start = 1'b1; a_kern = 2'd1;
    @(negedge clk);
    a_start = 1'b0;
    for (int k = 0; k < 30; k++) begin a_in = stim_a[k]; @(negedge clk); end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL abort_load_done got=%b exp=0", a_done); end
    n_tests++;
    if (a_out !== 8'h00) begin n_fail++; $display("FAIL abort_load_out got=%h exp=00", a_out); end
    n_tests++;
    if (a_state !== 2'd0) begin n_fail++; $display("FAIL abort_load_state got=%0d exp=0", a_state); end
    @(negedge clk);
    reset = 1'b1;
    // Abort mid-stream: done is high and image_out live, both must drop at once.
    stim_a.delete();
    for (int k = 0; k < N; k++) stim_a.push_back(8'($urandom_range(1, 255)));
    @(negedge clk);
    a_start = 1'b1; a_kern = 2'd0;
    @(negedge clk);
    a_start = 1'b0;
    for (int k = 0; k < N; k++) begin a_in = stim_a[k]; @(negedge clk); end
    repeat (10) @(negedge clk);
    n_tests++;
    if (a_out !== stim_a[9]) begin n_fail++; $display("FAIL pre_abort_out got=%h exp=%h", a_out, stim_a[9]); end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL abort_stream_done got=%b exp=0", a_done); end
    n_tests++;
    if (a_out !== 8'h00) begin n_fail++; $display("FAIL abort_stream_out got=%h exp=00", a_out); end
    @(negedge clk);
    reset = 1'b1;
    // A fresh frame after the abort completes normally.
    fill_a_random();
    build_exp_a(2'd1);
    run_frame_a(2'd1, 1'b0);
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (got_a[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL after_abort byte %0d got=%h exp=%h", k, got_a[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_corner_clamp();
    stim_b.delete();
    for (int k = 0; k < N2; k++) stim_b.push_back(8'h00);
    stim_b[0] = 8'h90;
    @(negedge clk);
    b_start = 1'b1; b_kern = 2'd1;
    @(negedge clk);
    b_start = 1'b0;
    for (int k = 0; k < N2; k++) begin b_in = stim_b[k]; @(negedge clk); end
    for (int k = 0; k < N2; k++) begin @(negedge clk); got_b[k] = b_out; end
    repeat (2) @(negedge clk);
    n_tests++;
    if (got_b[0] !== 8'h40) begin n_fail++; $display("FAIL corner_00 got=%h exp=40", got_b[0]); end
    n_tests++;
    if (got_b[9] !== 8'h10) begin n_fail++; $display("FAIL corner_11 got=%h exp=10", got_b[9]); end
    for (int k = 0; k < N2; k++) begin
      n_tests++;
      if (got_b[k] !== model_pix(stim_b, W2, H2, k, 2'd1)) begin
        n_fail++; $display("FAIL corner byte %0d got=%h exp=%h", k, got_b[k], model_pix(stim_b, W2, H2, k, 2'd1));
      end
    end
    n_tests++;
    if (b_done !== 1'b0) begin n_fail++; $display("FAIL corner_idle_done got=%b exp=0", b_done); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_constant();
    test_identity_ramp();
    test_impulse();
    test_random_kernels();
    test_kernel_hold();
    test_reset_abort();
    test_corner_clamp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
